// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO read/write controllers: pointer width
// derivation and Gray-code conversion.
package fifo_pkg;

    function automatic int unsigned addr_size(int unsigned depth);
        return $clog2(depth);
    endfunction

    // Operate at 32 bits; callers zero-extend and cast the result back.
    function automatic logic [31:0] bin2gray(logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= d;
            stage2_q <= stage1_q;
        end
    end

    assign q = stage2_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: read pointer, empty/level flags and a
// two-entry first-word-fall-through output stage in front of a registered memory.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned  DATASIZE  = 8,
    parameter int unsigned  DEPTH     = 16,
    parameter int unsigned  AE_THRESH = 2,
    localparam int unsigned ADDRSIZE  = addr_size(DEPTH)
) (
    input  logic                rd_clk,
    input  logic                rd_rst_n,
    input  logic [ADDRSIZE:0]   wr_ptr_gray,
    output logic [ADDRSIZE:0]   rd_ptr_gray,
    output logic [ADDRSIZE-1:0] rd_addr,
    output logic                rd_en,
    input  logic [DATASIZE-1:0] mem_data,
    output logic                empty,
    output logic                almost_empty,
    output logic [ADDRSIZE:0]   rd_level,
    output logic [DATASIZE-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready
);

    localparam int unsigned PTR_W = ADDRSIZE + 1;

    logic [ADDRSIZE:0]   wr_ptr_gray_sync;
    logic [ADDRSIZE:0]   wr_ptr_bin_sync;
    logic [ADDRSIZE:0]   rd_ptr_bin_q, rd_ptr_bin_d;
    logic [ADDRSIZE:0]   rd_ptr_gray_q, rd_ptr_gray_d;
    logic                rd_inflight_q;
    logic [DATASIZE-1:0] dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic [DATASIZE-1:0] skid_q, skid_d;
    logic                skid_valid_q, skid_valid_d;
    logic                pop;
    logic                ret_unplaced;
    logic [1:0]          pending;

    sync_2ff #(
        .WIDTH (PTR_W)
    ) u_wr_ptr_sync (
        .clk   (rd_clk),
        .rst_n (rd_rst_n),
        .d     (wr_ptr_gray),
        .q     (wr_ptr_gray_sync)
    );

    // Status flags come straight from registers, never from the raw async input.
    always_comb begin
        wr_ptr_bin_sync = PTR_W'(gray2bin(32'(wr_ptr_gray_sync)));
        rd_level        = wr_ptr_bin_sync - rd_ptr_bin_q;
        empty           = (rd_ptr_gray_q == wr_ptr_gray_sync);
        almost_empty    = (32'(rd_level) <= AE_THRESH);
    end

    always_comb begin
        pop           = dout_valid_q && dout_ready;
        pending       = 2'(dout_valid_q) + 2'(skid_valid_q) + 2'(rd_inflight_q);
        rd_en         = !empty && ((pending < 2'd2) || pop);
        rd_ptr_bin_d  = rd_ptr_bin_q + PTR_W'(rd_en);
        rd_ptr_gray_d = PTR_W'(bin2gray(32'(rd_ptr_bin_d)));
    end

    // Output stage: dout is always the oldest word; the skid entry only fills
    // when a returning word cannot go straight into dout.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        ret_unplaced = rd_inflight_q;
        if (!dout_valid_q || pop) begin
            if (skid_valid_q) begin
                dout_d       = skid_q;
                dout_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (rd_inflight_q) begin
                dout_d       = mem_data;
                dout_valid_d = 1'b1;
                ret_unplaced = 1'b0;
            end else begin
                dout_valid_d = 1'b0;
            end
        end
        if (ret_unplaced) begin
            skid_d       = mem_data;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rd_ptr_bin_q  <= '0;
            rd_ptr_gray_q <= '0;
            rd_inflight_q <= 1'b0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            skid_q        <= '0;
            skid_valid_q  <= 1'b0;
        end else begin
            rd_ptr_bin_q  <= rd_ptr_bin_d;
            rd_ptr_gray_q <= rd_ptr_gray_d;
            rd_inflight_q <= rd_en;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            skid_q        <= skid_d;
            skid_valid_q  <= skid_valid_d;
        end
    end

    assign rd_ptr_gray = rd_ptr_gray_q;
    assign rd_addr     = rd_ptr_bin_q[ADDRSIZE-1:0];
    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a behavioural memory plus a word-order scoreboard
// and pointer model, driven by directed and randomized scenarios.
module tb_fifo_rd_ctrl;

    logic       rd_clk = 1'b0;
    logic       rd_rst_n = 1'b0;
    logic [4:0] wr_ptr_gray = '0;
    logic [4:0] rd_ptr_gray;
    logic [3:0] rd_addr;
    logic       rd_en;
    logic [7:0] mem_data = '0;
    logic       empty;
    logic       almost_empty;
    logic [4:0] rd_level;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem [16];
    logic [7:0] exp_q [$];
    logic [4:0] wp = '0;
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    logic       hold_prev = 1'b0;
    logic [7:0] hold_dout = '0;

    fifo_rd_ctrl #(
        .DATASIZE  (8),
        .DEPTH     (16),
        .AE_THRESH (2)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst_n     (rd_rst_n),
        .wr_ptr_gray  (wr_ptr_gray),
        .rd_ptr_gray  (rd_ptr_gray),
        .rd_addr      (rd_addr),
        .rd_en        (rd_en),
        .mem_data     (mem_data),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_level     (rd_level),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready)
    );

    always #5 rd_clk = ~rd_clk;

    // Registered-read memory: data appears the cycle after the strobe.
    always @(posedge rd_clk) begin
        if (rd_en) mem_data <= mem[rd_addr];
    end

    function automatic logic [4:0] to_gray(logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    // Continuous model: read pointer tracks reads issued, stream follows write order.
    always @(negedge rd_clk) begin
        if (!rd_rst_n) begin
            rd_cnt = 0;
            hold_prev = 1'b0;
        end else begin
            vectors++;
            if (rd_ptr_gray !== to_gray(5'(rd_cnt)) || rd_addr !== 4'(rd_cnt)) begin
                miscompares++;
                $display("FAIL rd_pointer: gray=%b addr=%0d, required gray=%b addr=%0d",
                         rd_ptr_gray, rd_addr, to_gray(5'(rd_cnt)), 4'(rd_cnt));
            end
            if (rd_en) begin
                vectors++;
                if (rd_cnt >= wr_cnt) begin
                    miscompares++;
                    $display("FAIL read_overrun: read %0d issued, only %0d words written",
                             rd_cnt, wr_cnt);
                end
                rd_cnt++;
            end
            if (hold_prev) begin
                vectors++;
                if (dout_valid !== 1'b1 || dout !== hold_dout) begin
                    miscompares++;
                    $display("FAIL hold_stable: valid=%b dout=%h, required valid=1 dout=%h",
                             dout_valid, dout, hold_dout);
                end
            end
            if (dout_valid && dout_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL stream_extra: got word %h, required no word", dout);
                end else begin
                    if (dout !== exp_q[0]) begin
                        miscompares++;
                        $display("FAIL stream_order: got %h, required %h", dout, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            hold_prev = dout_valid && !dout_ready;
            hold_dout = dout;
        end
    end

    task automatic edge_wait();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push(int n);
        for (int i = 0; i < n; i++) begin
            mem[wp[3:0]] = 8'($urandom);
            exp_q.push_back(mem[wp[3:0]]);
            wp = wp + 5'd1;
            wr_cnt++;
        end
        wr_ptr_gray = to_gray(wp);
    endtask

    task automatic do_reset();
        edge_wait();
        rd_rst_n = 1'b0;
        wr_ptr_gray = '0;
        wp = '0;
        wr_cnt = 0;
        exp_q.delete();
        repeat (2) edge_wait();
        rd_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        wr_ptr_gray = to_gray(5'd3);
        repeat (3) @(negedge rd_clk);
        vectors++;
        if (empty !== 1'b1) begin
            miscompares++; $display("FAIL reset_empty: got %b, required 1", empty);
        end
        vectors++;
        if (almost_empty !== 1'b1) begin
            miscompares++; $display("FAIL reset_almost_empty: got %b, required 1", almost_empty);
        end
        vectors++;
        if (rd_level !== 5'd0) begin
            miscompares++; $display("FAIL reset_level: got %0d, required 0", rd_level);
        end
        vectors++;
        if (rd_en !== 1'b0) begin
            miscompares++; $display("FAIL reset_rd_en: got %b, required 0", rd_en);
        end
        vectors++;
        if (dout_valid !== 1'b0 || dout !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_dout: valid=%b dout=%h, required 0/00", dout_valid, dout);
        end
        vectors++;
        if (rd_ptr_gray !== 5'd0) begin
            miscompares++; $display("FAIL reset_rd_ptr: got %b, required 00000", rd_ptr_gray);
        end
    endtask

    task automatic test_single();
        logic [7:0] w0;
        logic       exp_empty, exp_rd, exp_dv;
        edge_wait();
        wr_ptr_gray = '0;
        dout_ready = 1'b1;
        rd_rst_n = 1'b1;
        repeat (3) edge_wait();
        push(1);
        w0 = exp_q[0];
        for (int e = 1; e <= 5; e++) begin
            @(posedge rd_clk);
            @(negedge rd_clk);
            exp_empty = (e != 2);
            exp_rd = (e == 2);
            exp_dv = (e == 4);
            vectors++;
            if (empty !== exp_empty || rd_en !== exp_rd || dout_valid !== exp_dv) begin
                miscompares++;
                $display("FAIL single_latency edge %0d: empty=%b rd_en=%b valid=%b, required %b %b %b",
                         e, empty, rd_en, dout_valid, exp_empty, exp_rd, exp_dv);
            end
            if (e == 2) begin
                vectors++;
                if (rd_addr !== 4'd0) begin
                    miscompares++; $display("FAIL single_addr: got %0d, required 0", rd_addr);
                end
            end
            if (e == 4) begin
                vectors++;
                if (dout !== w0) begin
                    miscompares++; $display("FAIL single_data: got %h, required %h", dout, w0);
                end
            end
        end
    endtask

    task automatic test_burst();
        int n_rd = 0, first_rd = -1, last_rd = -1;
        int n_dv = 0, first_dv = -1, last_dv = -1;
        do_reset();
        dout_ready = 1'b1;
        push(16);
        for (int c = 0; c < 30; c++) begin
            @(posedge rd_clk);
            @(negedge rd_clk);
            if (rd_en) begin
                if (first_rd < 0) first_rd = c;
                last_rd = c;
                n_rd++;
            end
            if (dout_valid) begin
                if (first_dv < 0) first_dv = c;
                last_dv = c;
                n_dv++;
            end
        end
        vectors++;
        if (n_rd != 16 || last_rd - first_rd != 15) begin
            miscompares++;
            $display("FAIL burst_reads: %0d reads over span %0d, required 16 over 15",
                     n_rd, last_rd - first_rd);
        end
        vectors++;
        if (n_dv != 16 || last_dv - first_dv != 15) begin
            miscompares++;
            $display("FAIL burst_stream: %0d words over span %0d, required 16 over 15",
                     n_dv, last_dv - first_dv);
        end
        vectors++;
        if (empty !== 1'b1 || rd_level !== 5'd0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL burst_drained: empty=%b level=%0d left=%0d, required 1/0/0",
                     empty, rd_level, exp_q.size());
        end
    endtask

    task automatic test_stall();
        int n_rd = 0;
        do_reset();
        dout_ready = 1'b0;
        push(4);
        for (int c = 0; c < 10; c++) begin
            @(posedge rd_clk);
            @(negedge rd_clk);
            if (rd_en) n_rd++;
        end
        vectors++;
        if (n_rd != 2) begin
            miscompares++; $display("FAIL stall_reads: got %0d reads, required 2", n_rd);
        end
        vectors++;
        if (rd_level !== 5'd2 || almost_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_level: level=%0d ae=%b, required 2/1", rd_level, almost_empty);
        end
        vectors++;
        if (dout_valid !== 1'b1 || dout !== exp_q[0]) begin
            miscompares++;
            $display("FAIL stall_head: valid=%b dout=%h, required 1/%h", dout_valid, dout, exp_q[0]);
        end
        edge_wait();
        dout_ready = 1'b1;
        repeat (12) @(negedge rd_clk);
        vectors++;
        if (exp_q.size() != 0 || empty !== 1'b1 || rd_level !== 5'd0 || dout_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_resume: left=%0d empty=%b level=%0d valid=%b, required 0/1/0/0",
                     exp_q.size(), empty, rd_level, dout_valid);
        end
    endtask

    task automatic test_wrap_random();
        int         written = 0;
        int         n;
        logic       saw_wrap = 1'b0;
        logic [4:0] prev_g;
        prev_g = rd_ptr_gray;
        for (int c = 0; c < 400 && !(written == 40 && exp_q.size() == 0); c++) begin
            edge_wait();
            dout_ready = ($urandom_range(0, 3) != 0);
            if (written < 40) begin
                n = $urandom_range(1, 4);
                if (n > 40 - written) n = 40 - written;
                if (exp_q.size() + n <= 16) begin
                    push(n);
                    written += n;
                end
            end
            @(negedge rd_clk);
            vectors++;
            if (rd_level > 5'd16 || empty !== (rd_level == 5'd0) ||
                almost_empty !== (rd_level <= 5'd2)) begin
                miscompares++;
                $display("FAIL wrap_flags: level=%0d empty=%b ae=%b, required level<=16 consistent",
                         rd_level, empty, almost_empty);
            end
            if (prev_g == 5'b10000 && rd_ptr_gray == 5'b00000) saw_wrap = 1'b1;
            prev_g = rd_ptr_gray;
        end
        vectors++;
        if (written != 40 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL wrap_timeout: written=%0d left=%0d, required 40/0", written, exp_q.size());
        end
        vectors++;
        if (saw_wrap !== 1'b1 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_pointer: saw_wrap=%b empty=%b, required 1/1", saw_wrap, empty);
        end
    endtask

    task automatic test_reset_mid();
        logic [22:0] got, req;
        do_reset();
        dout_ready = 1'b1;
        push(8);
        repeat (5) @(posedge rd_clk);
        edge_wait();
        vectors++;
        if (dout_valid !== 1'b1 || rd_en !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_setup: valid=%b rd_en=%b, required 1/1", dout_valid, rd_en);
        end
        rd_rst_n = 1'b0;
        wr_ptr_gray = '0;
        wp = '0;
        wr_cnt = 0;
        exp_q.delete();
        #1;
        got = {dout_valid, rd_en, empty, almost_empty, rd_level, rd_ptr_gray, dout};
        req = {1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 8'h00};
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL midrst_outputs: got %h, required %h", got, req);
        end
        repeat (2) edge_wait();
        rd_rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge rd_clk);
            @(negedge rd_clk);
            vectors++;
            if (dout_valid !== 1'b0 || rd_en !== 1'b0 || empty !== 1'b1) begin
                miscompares++;
                $display("FAIL midrst_stale cycle %0d: valid=%b rd_en=%b empty=%b, required 0/0/1",
                         c, dout_valid, rd_en, empty);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_stall();
        test_wrap_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
